// File: rtl/rx_frame_pkg.sv
// Shared constants for the RX frame controller: state encoding, preamble bytes,
// counter and timer widths.
package rx_frame_pkg;

  localparam int LEN_W = 16;
  localparam int CNT_W = 16;
  localparam int TMR_W = 20;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_HDR_L    = 3'd1;
  localparam state_t ST_HDR_H    = 3'd2;
  localparam state_t ST_EMIT_HDR = 3'd3;
  localparam state_t ST_DATA     = 3'd4;
  localparam state_t ST_PAD      = 3'd5;

  localparam logic [7:0] PREAMBLE_A = 8'h55;
  localparam logic [7:0] PREAMBLE_B = 8'hAA;

  function automatic logic is_preamble(input logic [7:0] b);
    return (b == PREAMBLE_A) || (b == PREAMBLE_B);
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_timer.sv
// rx_byte_timer: counts idle cycles while armed; pulses o_expire on the
// TIMEOUT_CYCLES-th consecutive cycle without a byte. Used only with RX_FRAME_TIMEOUT_EN.
module rx_byte_timer
  import rx_frame_pkg::*;
#(
  parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic i_rx_clk,
  input  logic i_rx_rst_n,
  input  logic i_arm,
  input  logic i_clear,
  output logic o_expire
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    cnt_d    = cnt_q;
    o_expire = 1'b0;
    if (!i_arm || i_clear) begin
      cnt_d = '0;
    end else if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
      o_expire = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking belongs in always_comb.
  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// RX frame controller: detects preamble, parses a 16-bit length, re-emits header
// and payload as registered byte strobes. Optional idle timeout under RX_FRAME_TIMEOUT_EN.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [LEN_W-1:0] MAX_LEN        = 16'd1024,
  parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic             i_rx_clk,
  input  logic             i_rx_rst_n,
  input  logic             i_enable,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic [31:0]      o_rx_data,
  output logic             o_rx_data_valid,
  output logic             o_rx_sof,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  state_t             state_q, state_d;
  logic [7:0]         pre_q, pre_d;
  logic [7:0]         len_l_q, len_l_d;
  logic [7:0]         len_h_q, len_h_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         skid_q, skid_d;
  logic               skid_vld_q, skid_vld_d;
  logic [7:0]         data_q, data_d;
  logic               dvalid_q, dvalid_d;
  logic               sof_q, sof_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               drop_inc;
  logic               expire;
  logic [LEN_W-1:0]   len_full;

  assign len_full = {i_byte, len_l_q};

`ifdef RX_FRAME_TIMEOUT_EN
  logic tmr_arm;
  // Timer runs only while waiting on the sender; a pending skid byte counts as progress.
  assign tmr_arm = (state_q == ST_HDR_L) || (state_q == ST_HDR_H) ||
                   ((state_q == ST_DATA) && !skid_vld_q);

  rx_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_rx_clk   (i_rx_clk),
    .i_rx_rst_n (i_rx_rst_n),
    .i_arm      (tmr_arm),
    .i_clear    (i_byte_valid),
    .o_expire   (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    len_l_d     = len_l_q;
    len_h_d     = len_h_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    data_d      = 8'h00;
    dvalid_d    = 1'b0;
    sof_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    drop_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_byte_valid && is_preamble(i_byte)) begin
          pre_d   = i_byte;
          state_d = ST_HDR_L;
        end
      end
      ST_HDR_L: begin
        if (i_byte_valid) begin
          len_l_d = i_byte;
          state_d = ST_HDR_H;
        end else if (expire) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_HDR_H: begin
        if (i_byte_valid) begin
          len_h_d = i_byte;
          rem_d   = len_full;
          if ((len_full != '0) && (len_full <= MAX_LEN)) begin
            idx_d   = 2'd0;
            state_d = ST_EMIT_HDR;
          end else begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (expire) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_EMIT_HDR: begin
        dvalid_d = 1'b1;
        case (idx_q)
          2'd0: begin
            data_d = pre_q;
            sof_d  = 1'b1;
          end
          2'd1:    data_d = len_l_q;
          default: data_d = len_h_q;
        endcase
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) state_d = ST_DATA;
        // The skid holds the first byte only; it is never overwritten before it drains.
        if (i_byte_valid && !skid_vld_q) begin
          skid_d     = i_byte;
          skid_vld_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (skid_vld_q) begin
          dvalid_d   = 1'b1;
          data_d     = skid_q;
          skid_vld_d = 1'b0;
          if (i_byte_valid && (rem_q != 16'd1)) begin
            skid_d     = i_byte;
            skid_vld_d = 1'b1;
          end
        end else if (i_byte_valid) begin
          dvalid_d = 1'b1;
          data_d   = i_byte;
        end else if (expire) begin
          state_d = ST_PAD;
        end
        if (dvalid_d) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            skid_vld_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_PAD: begin
        dvalid_d = 1'b1;
        rem_d    = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // NOTE: the skid and header holding registers are reset too; they are single flops, not a RAM.
  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      len_l_q     <= '0;
      len_h_q     <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      data_q      <= '0;
      dvalid_q    <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      len_l_q     <= len_l_d;
      len_h_q     <= len_h_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_rx_data       = {24'h000000, data_q};
  assign o_rx_data_valid = dvalid_q;
  assign o_rx_sof        = sof_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_frame_cnt     = frame_cnt_q;
  assign o_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: directed scenarios plus random frames
// checked against a frame-level expected-output queue.
module tb_rx_frame_ctrl;

  localparam int MAX_LEN = 1024;

  logic        i_rx_clk = 1'b0;
  logic        i_rx_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic [31:0] o_rx_data;
  logic        o_rx_data_valid;
  logic        o_rx_sof;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;

  always #5 i_rx_clk = ~i_rx_clk;

  rx_frame_ctrl #(.MAX_LEN(16'd1024), .TIMEOUT_CYCLES(20'd50)) dut (
    .i_rx_clk        (i_rx_clk),
    .i_rx_rst_n      (i_rx_rst_n),
    .i_enable        (i_enable),
    .i_byte          (i_byte),
    .i_byte_valid    (i_byte_valid),
    .o_rx_data       (o_rx_data),
    .o_rx_data_valid (o_rx_data_valid),
    .o_rx_sof        (o_rx_sof),
    .o_busy          (o_busy),
    .o_frame_cnt     (o_frame_cnt),
    .o_drop_cnt      (o_drop_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge i_rx_clk) cyc <= cyc + 1;

  // Output monitor: records every emitted byte with its sof flag and cycle stamp.
  always @(negedge i_rx_clk) begin
    if (o_rx_data_valid) begin
      got_q.push_back({o_rx_sof, o_rx_data[7:0]});
      got_t.push_back(cyc);
      check("data_hi_zero", {8'h00, o_rx_data[31:8]}, 32'h0);
    end
    if (o_rx_sof) check("sof_with_valid", {31'h0, o_rx_data_valid}, 32'h1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_rx_clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge i_rx_clk);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge i_rx_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic expect_byte(input logic sof, input logic [7:0] b);
    exp_q.push_back({sof, b});
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, {23'h0, got_q[i]}, {23'h0, exp_q[i]});
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, {16'h0, o_frame_cnt}, exp_frames);
    check({tag, "_drop_cnt"}, {16'h0, o_drop_cnt}, exp_drops);
    check({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
  endtask

  // Send a full frame; the expected stream follows directly from the framing rules.
  task automatic frame(input logic [7:0] pre, input logic [15:0] len, input int gmin,
                       input int gmax, input bit rand_en);
    logic [7:0] b;
    bit legal;
    legal = (len != 16'd0) && (int'(len) <= MAX_LEN);
    i_enable = 1'b1;
    send(pre, $urandom_range(gmin, gmax));
    if (rand_en) i_enable = 1'($urandom_range(0, 1));
    send(len[7:0], $urandom_range(gmin, gmax));
    if (rand_en) i_enable = 1'($urandom_range(0, 1));
    send(len[15:8], $urandom_range(gmin, gmax));
    if (legal) begin
      expect_byte(1'b1, pre);
      expect_byte(1'b0, len[7:0]);
      expect_byte(1'b0, len[15:8]);
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        if (rand_en) i_enable = 1'($urandom_range(0, 1));
        send(b, $urandom_range(gmin, gmax));
        expect_byte(1'b0, b);
      end
      exp_frames++;
    end else begin
      exp_drops++;
    end
    i_enable = 1'b1;
    idle(4);
  endtask

  initial begin
    logic [7:0]  junk;
    logic [15:0] rlen;

    // Reset state
    idle(3);
    check("rst_data", o_rx_data, 32'h0);
    check("rst_valid", {31'h0, o_rx_data_valid}, 32'h0);
    check("rst_sof", {31'h0, o_rx_sof}, 32'h0);
    check_counters("rst");
    i_rx_rst_n = 1'b1;
    idle(2);

    // Basic frame, bytes 10 cycles apart
    i_enable = 1'b1;
    send(8'h55, 9); send(8'h03, 9); send(8'h00, 9);
    send(8'hA1, 9); send(8'hA2, 9); send(8'hA3, 9);
    idle(4);
    expect_byte(1'b1, 8'h55); expect_byte(1'b0, 8'h03); expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hA1); expect_byte(1'b0, 8'hA2); expect_byte(1'b0, 8'hA3);
    exp_frames++;
    compare_stream("basic");
    check_counters("basic");

    // Illegal lengths: zero, and MAX_LEN+1
    frame(8'hAA, 16'd0, 2, 4, 1'b0);
    compare_stream("len0");
    check_counters("len0");
    frame(8'hAA, 16'd1025, 2, 4, 1'b0);
    compare_stream("len1025");
    check_counters("len1025");

    // Largest legal length
    frame(8'hAA, 16'd1024, 2, 2, 1'b0);
    compare_stream("len1024");
    check_counters("len1024");

    // Byte right after len_h lands in the skid and follows len_h with no gap
    send(8'h55, 2); send(8'h02, 2); send(8'h00, 2);
    send(8'hA1, 0);
    send(8'hB2, 5);
    idle(4);
    check("skid_seen", {31'h0, got_t.size() >= 4}, 32'h1);
    if (got_t.size() >= 4) check("skid_adjacent", got_t[3] - got_t[2], 32'd1);
    expect_byte(1'b1, 8'h55); expect_byte(1'b0, 8'h02); expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hA1); expect_byte(1'b0, 8'hB2);
    exp_frames++;
    compare_stream("skid");
    check_counters("skid");

    // Non-preamble byte and preamble while disabled are ignored
    send(8'h12, 3);
    i_enable = 1'b0;
    send(8'h55, 3);
    i_enable = 1'b1;
    idle(4);
    compare_stream("ignored");
    check_counters("ignored");

    // Reset mid-header discards the frame and clears counters
    send(8'h55, 2); send(8'h05, 2);
    check("midrst_busy", {31'h0, o_busy}, 32'h1);
    i_rx_rst_n = 1'b0;
    idle(2);
    exp_frames = 0;
    exp_drops  = 0;
    check_counters("midrst");
    i_rx_rst_n = 1'b1;
    send(8'h00, 2);
    idle(4);
    compare_stream("midrst");
    check_counters("midrst_after");

    // Random frames with junk, disabled preambles and enable toggling mid-frame
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h55 || junk == 8'hAA) junk = 8'h3C;
        send(junk, 2);
      end
      if ($urandom_range(0, 3) == 0) begin
        i_enable = 1'b0;
        send(8'h55, 2);
        i_enable = 1'b1;
      end
      case ($urandom_range(0, 4))
        0:       rlen = $urandom_range(0, 1) ? 16'd0 : 16'(MAX_LEN + $urandom_range(1, 40));
        default: rlen = 16'($urandom_range(1, 12));
      endcase
      frame($urandom_range(0, 1) ? 8'h55 : 8'hAA, rlen, 2, 5, 1'b1);
      compare_stream("rand");
      check_counters("rand");
    end

`ifdef RX_FRAME_TIMEOUT_EN
    // Payload gap expires: remaining bytes padded with zeros, frame counted as dropped
    send(8'h55, 2); send(8'h04, 9); send(8'h00, 9); send(8'hB1, 9);
    idle(80);
    expect_byte(1'b1, 8'h55); expect_byte(1'b0, 8'h04); expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hB1);
    expect_byte(1'b0, 8'h00); expect_byte(1'b0, 8'h00); expect_byte(1'b0, 8'h00);
    exp_drops++;
    compare_stream("tmo_pad");
    check_counters("tmo_pad");

    // Header gap expires: back to idle, nothing emitted
    send(8'hAA, 2);
    idle(80);
    exp_drops++;
    compare_stream("tmo_hdr");
    check_counters("tmo_hdr");
`else
    // Without the timeout a frame waits indefinitely for its payload
    send(8'h55, 2); send(8'h02, 2); send(8'h00, 2); send(8'hC1, 2);
    idle(300);
    check("wait_busy", {31'h0, o_busy}, 32'h1);
    check("wait_partial", got_q.size(), 32'd4);
    send(8'hC2, 2);
    idle(4);
    expect_byte(1'b1, 8'h55); expect_byte(1'b0, 8'h02); expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hC1); expect_byte(1'b0, 8'hC2);
    exp_frames++;
    compare_stream("no_tmo");
    check_counters("no_tmo");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16'd1024: largest legal payload length in bytes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20'd100000: allowed idle i_rx_clk cycles between bytes inside a frame.
REQ-003 SHALL have i_rx_clk  input  1  clock; reset i_rx_rst_n, asynchronous, active-low; clock i_rx_clk.
REQ-004 SHALL have i_rx_rst_n  input  1  async active-low reset.
REQ-005 SHALL have i_enable  input  1  accept new frames when high.
REQ-006 SHALL have i_byte  input  8  received byte from UART deserialiser.
REQ-007 SHALL have i_byte_valid  input  1  one-cycle strobe qualifying i_byte.
REQ-008 SHALL have o_rx_data  output  32  [7:0] emitted byte, [31:8] always zero.
REQ-009 SHALL have o_rx_data_valid  output  1  one-cycle strobe per emitted byte.
REQ-010 SHALL have o_rx_sof  output  1  high with the first emitted byte (preamble) of a frame.
REQ-011 SHALL have o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have o_frame_cnt  output  16  frames fully emitted; wraps at 16'hFFFF.
REQ-013 SHALL have o_drop_cnt  output  16  frames rejected or timed out; saturates at 16'hFFFF.

Function
REQ-014 SHALL use states IDLE, HDR_L, HDR_H, EMIT_HDR, DATA, PAD.
REQ-015 In IDLE with i_enable=1, a valid byte of 8'h55 or 8'hAA SHALL be latched as preamble, next state HDR_L; any other byte is discarded.
REQ-016 HDR_L SHALL latch the valid byte as length[7:0]; HDR_H SHALL latch length[15:8].
REQ-017 After HDR_H, length==0 or length>MAX_LEN SHALL increment o_drop_cnt, return to IDLE and emit nothing.
REQ-018 Legal length SHALL enter EMIT_HDR: emit preamble, len_l, len_h on three consecutive cycles, o_rx_sof high on the first only, then enter DATA.
REQ-019 A byte arriving during EMIT_HDR SHALL be held in a 1-entry skid register and emitted on the cycle after len_h; the skid register SHALL never be overwritten.
REQ-020 DATA SHALL forward each valid byte with 1-cycle latency and decrement a 16-bit remaining count; reaching 0 increments o_frame_cnt and returns to IDLE.
REQ-021 i_enable deasserted mid-frame SHALL NOT abort; the frame completes.
REQ-022 Outputs SHALL be registered; at most one o_rx_data_valid per cycle.

Reset
REQ-023 Reset SHALL force IDLE, all outputs 0, counters 0, skid empty; reset mid-frame SHALL discard the frame without incrementing any counter.

Configuration
REQ-024 With RX_FRAME_TIMEOUT_EN defined: in HDR_L/HDR_H a gap of TIMEOUT_CYCLES cycles SHALL return to IDLE and increment o_drop_cnt; in DATA it SHALL enter PAD.
REQ-025 PAD SHALL emit 8'h00 once per cycle until remaining count is 0, then increment o_drop_cnt (not o_frame_cnt), go IDLE; bytes arriving in PAD are discarded.
REQ-026 Without RX_FRAME_TIMEOUT_EN: no timer logic, PAD unreachable, frames wait indefinitely.

Structure
REQ-027 State encoding, preamble constants 8'h55/8'hAA and counter widths SHALL reside in package rx_frame_pkg.
REQ-028 Timeout counter SHALL be sub-module rx_byte_timer (clear on byte, expire pulse), instantiated only under RX_FRAME_TIMEOUT_EN.

Verification
REQ-029 Bytes 55,03,00,A1,A2,A3 spaced 10 cycles -> 6 valid strobes, sof on 55, o_frame_cnt=1, o_drop_cnt=0.
REQ-030 Bytes AA,00,00 -> no output, o_drop_cnt=1; same with length 16'd1025 -> o_drop_cnt=2.
REQ-031 Byte 55 then length 02,00 then A1 one cycle after len_h accepted -> A1 emitted immediately after len_h via skid, no loss.
REQ-032 With macro, TIMEOUT_CYCLES=50: 55,04,00,B1 then silence -> B1 followed by three 00 pad strobes, o_drop_cnt=1, state IDLE.
REQ-033 Byte 12 in IDLE, and 55 with i_enable=0 -> ignored; reset asserted after HDR_L -> all counters 0, no output.
